// File: rtl/sid_env_sched_if.sv
// Bus bundle between the SID register file, the envelope scheduler and the voice DCAs.
interface sid_env_sched_if #(
    parameter int unsigned NVOICE = 3
);
    logic                tick;
    logic [8*NVOICE-1:0] ad_flat;
    logic [8*NVOICE-1:0] sr_flat;
    logic [NVOICE-1:0]   gate;
    logic [8*NVOICE-1:0] env_flat;
    logic                env_valid;
    logic                busy;
    logic                overrun;
    logic [7:0]          env3;

    modport master (
        output tick, ad_flat, sr_flat, gate,
        input  env_flat, env_valid, busy, overrun, env3
    );
    modport slave (
        input  tick, ad_flat, sr_flat, gate,
        output env_flat, env_valid, busy, overrun, env3
    );
endinterface

// File: rtl/sid_env_sched.sv
// Time-multiplexed SID ADSR envelope sequencer: one shared datapath, one voice per clk slot.
// Optional ENV3 readback register enabled by defining SID_ENV_ENV3_READ_EN.
module sid_env_sched #(
    parameter int unsigned NVOICE = 3,
    parameter int unsigned RCW    = 15
) (
    input logic            clk,
    input logic            reset,
    sid_env_sched_if.slave bus
);
    localparam int unsigned SW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam logic [SW-1:0] LastSlot = SW'(NVOICE - 1);

    typedef enum logic [1:0] {StIdle, StServe, StDone} sched_e;
    typedef enum logic [1:0] {Attack, DecaySustain, Release} adsr_e;

    sched_e        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          service;

    logic [7:0]     env_q      [NVOICE];
    logic [RCW-1:0] rate_cnt_q [NVOICE];
    logic [4:0]     exp_cnt_q  [NVOICE];
    adsr_e          adsr_q     [NVOICE];
    logic [NVOICE-1:0] gate_last_q;

    logic [7:0]     ad_v, sr_v, env_v, env_n;
    logic [RCW-1:0] rc_v, rc_n, period;
    logic [4:0]     ec_v, ec_n, exp_period;
    logic [3:0]     rate;
    adsr_e          adsr_eff, adsr_n;
    logic           gate_v, do_step;

    function automatic logic [RCW-1:0] rate_period(input logic [3:0] r);
        logic [RCW-1:0] p;
        case (r)
            4'd0:    p = RCW'(9);
            4'd1:    p = RCW'(32);
            4'd2:    p = RCW'(63);
            4'd3:    p = RCW'(95);
            4'd4:    p = RCW'(149);
            4'd5:    p = RCW'(220);
            4'd6:    p = RCW'(267);
            4'd7:    p = RCW'(313);
            4'd8:    p = RCW'(392);
            4'd9:    p = RCW'(977);
            4'd10:   p = RCW'(1954);
            4'd11:   p = RCW'(3126);
            4'd12:   p = RCW'(3907);
            4'd13:   p = RCW'(11720);
            4'd14:   p = RCW'(19532);
            default: p = RCW'(31251);
        endcase
        return p;
    endfunction

    // Piecewise-exponential decay: fewer steps per rate event at low levels.
    function automatic logic [4:0] exp_period_of(input logic [7:0] e);
        logic [4:0] p;
        if (e == 8'h00)      p = 5'd1;
        else if (e <= 8'h06) p = 5'd30;
        else if (e <= 8'h0e) p = 5'd16;
        else if (e <= 8'h1a) p = 5'd8;
        else if (e <= 8'h36) p = 5'd4;
        else if (e <= 8'h5d) p = 5'd2;
        else                 p = 5'd1;
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle: begin
                if (bus.tick || pending_q) begin
                    state_d   = StServe;
                    slot_d    = '0;
                    pending_d = 1'b0;
                end
            end
            StServe: begin
                if (slot_q == LastSlot) state_d = StDone;
                else                    slot_d  = slot_q + 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // One tick may queue behind a running service; a further one is lost.
        if (state_q != StIdle && bus.tick) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_comb begin
        service       = (state_q == StServe);
        bus.busy      = (state_q != StIdle);
        bus.env_valid = (state_q == StDone);
        bus.overrun   = overrun_q;
    end

    always_comb begin
        ad_v     = bus.ad_flat[{slot_q, 3'b000} +: 8];
        sr_v     = bus.sr_flat[{slot_q, 3'b000} +: 8];
        gate_v   = bus.gate[slot_q];
        env_v    = env_q[slot_q];
        rc_v     = rate_cnt_q[slot_q];
        ec_v     = exp_cnt_q[slot_q];
        adsr_eff = adsr_q[slot_q];
        if (gate_v && !gate_last_q[slot_q])      adsr_eff = Attack;
        else if (!gate_v && gate_last_q[slot_q]) adsr_eff = Release;
        case (adsr_eff)
            Attack:       rate = ad_v[7:4];
            DecaySustain: rate = ad_v[3:0];
            default:      rate = sr_v[3:0];
        endcase
        period     = rate_period(rate);
        exp_period = exp_period_of(env_v);
        rc_n       = rc_v + 1'b1;
        ec_n       = ec_v;
        env_n      = env_v;
        adsr_n     = adsr_eff;
        do_step    = 1'b0;
        // >= rather than == so a freshly lowered rate cannot overshoot and wrap.
        if (rc_v >= period) begin
            rc_n = '0;
            if (adsr_eff == Attack || ec_v == exp_period) begin
                do_step = 1'b1;
                ec_n    = '0;
            end else begin
                ec_n = ec_v + 1'b1;
            end
        end
        if (do_step) begin
            case (adsr_eff)
                Attack: begin
                    if (env_v == 8'hff) adsr_n = DecaySustain;
                    else                env_n  = env_v + 1'b1;
                end
                // Only decay from above the sustain level; a raised sustain just holds.
                DecaySustain: if (env_v > {sr_v[7:4], sr_v[7:4]}) env_n = env_v - 1'b1;
                default:      if (env_v != 8'h00) env_n = env_v - 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NVOICE; i++) begin
                env_q[i]      <= '0;
                rate_cnt_q[i] <= '0;
                exp_cnt_q[i]  <= '0;
                adsr_q[i]     <= Release;
            end
            gate_last_q <= '0;
        end else if (service) begin
            env_q[slot_q]       <= env_n;
            rate_cnt_q[slot_q]  <= rc_n;
            exp_cnt_q[slot_q]   <= ec_n;
            adsr_q[slot_q]      <= adsr_n;
            gate_last_q[slot_q] <= gate_v;
        end
    end

    for (genvar g = 0; g < NVOICE; g++) begin : g_env_out
        assign bus.env_flat[8*g +: 8] = env_q[g];
    end

`ifdef SID_ENV_ENV3_READ_EN
    logic [7:0] env3_q;
    always_ff @(posedge clk) begin
        if (reset)                               env3_q <= '0;
        else if (service && slot_q == SW'(2))    env3_q <= env_n;
    end
    assign bus.env3 = env3_q;
`else
    assign bus.env3 = 8'h00;
`endif
endmodule

// File: tb/tb_sid_env_sched.sv
// Self-checking bench for sid_env_sched: per-tick envelope model feeding a scoreboard queue.
module tb_sid_env_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sid_env_sched_if bus ();
    sid_env_sched dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [23:0] sb_q[$];
    int per_tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907,
                         11720, 19532, 31251};
    logic [7:0] m_env [3];
    int         m_rc  [3];
    int         m_ec  [3];
    int         m_st  [3];   // 0 attack, 1 decay/sustain, 2 release
    logic       m_gl  [3];
    int         last_lat;
    logic       busy_mid;

    function automatic int exp_per(input logic [7:0] e);
        if (e == 8'h00) return 1;
        if (e < 8'h07)  return 30;
        if (e < 8'h0f)  return 16;
        if (e < 8'h1b)  return 8;
        if (e < 8'h37)  return 4;
        if (e < 8'h5e)  return 2;
        return 1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 3; v++) begin
            m_env[v] = 8'h00; m_rc[v] = 0; m_ec[v] = 0; m_st[v] = 2; m_gl[v] = 1'b0;
        end
        sb_q.delete();
    endtask

    task automatic model_tick();
        for (int v = 0; v < 3; v++) begin
            logic [7:0] a, s;
            logic       g, stp;
            int         rate;
            a = bus.ad_flat[8*v +: 8];
            s = bus.sr_flat[8*v +: 8];
            g = bus.gate[v];
            if (g && !m_gl[v])      m_st[v] = 0;
            else if (!g && m_gl[v]) m_st[v] = 2;
            m_gl[v] = g;
            if (m_st[v] == 0)      rate = int'(a[7:4]);
            else if (m_st[v] == 1) rate = int'(a[3:0]);
            else                   rate = int'(s[3:0]);
            stp = 1'b0;
            if (m_rc[v] >= per_tab[rate]) begin
                m_rc[v] = 0;
                if (m_st[v] == 0 || m_ec[v] == exp_per(m_env[v])) begin
                    stp = 1'b1;
                    m_ec[v] = 0;
                end else begin
                    m_ec[v]++;
                end
            end else begin
                m_rc[v]++;
            end
            if (stp) begin
                if (m_st[v] == 0) begin
                    if (m_env[v] == 8'hff) m_st[v] = 1;
                    else m_env[v] = m_env[v] + 8'd1;
                end else if (m_st[v] == 1) begin
                    if (m_env[v] > {s[7:4], s[7:4]}) m_env[v] = m_env[v] - 8'd1;
                end else if (m_env[v] != 8'h00) begin
                    m_env[v] = m_env[v] - 8'd1;
                end
            end
        end
        sb_q.push_back({m_env[2], m_env[1], m_env[0]});
    endtask

    // Scoreboard monitor: every env_valid pops one expected envelope snapshot.
    always @(negedge clk) begin
        if (!reset && bus.env_valid) begin
            logic [23:0] exp_e;
            logic [7:0]  exp3;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: env_valid with empty scoreboard, env_flat=%h",
                         bus.env_flat);
            end else begin
                exp_e = sb_q.pop_front();
                if (bus.env_flat !== exp_e) begin
                    bad++;
                    $display("FAIL sb_env: env_flat=%h expected=%h at %0t", bus.env_flat,
                             exp_e, $time);
                end
`ifdef SID_ENV_ENV3_READ_EN
                exp3 = exp_e[23:16];
`else
                exp3 = 8'h00;
`endif
                total++;
                if (bus.env3 !== exp3) begin
                    bad++;
                    $display("FAIL sb_env3: env3=%h expected=%h", bus.env3, exp3);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        bus.tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Entered and left on a negedge with the scheduler idle.
    task automatic do_tick();
        int lat;
        model_tick();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        busy_mid = bus.busy;
        lat = 1;
        while (!bus.env_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.env_valid) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: no env_valid within %0d clk, required 4", lat);
            sb_q.delete();
        end
        last_lat = lat;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ad_flat = '0; bus.sr_flat = '0; bus.gate = '0; bus.tick = 1'b0;
        apply_reset();
        total++; if (bus.env_flat !== 24'h0) begin bad++;
            $display("FAIL reset_env: got %h want 000000", bus.env_flat); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.env_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", bus.env_valid); end
        total++; if (bus.overrun !== 1'b0) begin bad++;
            $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        total++; if (bus.env3 !== 8'h00) begin bad++;
            $display("FAIL reset_env3: got %h want 00", bus.env3); end
    endtask

    task automatic test_latency();
        do_tick();
        total++; if (last_lat !== 4) begin bad++;
            $display("FAIL latency: got %0d clk want 4", last_lat); end
        total++; if (busy_mid !== 1'b1) begin bad++;
            $display("FAIL busy_mid: got %b want 1", busy_mid); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_attack();
        apply_reset();
        bus.ad_flat = 24'h000000;
        bus.sr_flat = 24'h80f0f0;
        bus.gate    = 3'b111;
        repeat (2549) do_tick();
        total++; if (bus.env_flat[7:0] !== 8'hfe) begin bad++;
            $display("FAIL attack_2549: env0=%h want fe", bus.env_flat[7:0]); end
        repeat (11) do_tick();
        total++; if (bus.env_flat[7:0] !== 8'hff) begin bad++;
            $display("FAIL attack_2560: env0=%h want ff", bus.env_flat[7:0]); end
        repeat (20) do_tick();
        total++; if (bus.env_flat[7:0] !== 8'hff) begin bad++;
            $display("FAIL attack_hold: env0=%h want ff", bus.env_flat[7:0]); end
    endtask

    task automatic test_release_regate();
        int   n = 0;
        int   rg = 0;
        logic regated = 1'b0;
        logic checked = 1'b0;
        bus.gate = 3'b100;
        while (m_env[0] != 8'h00 && n < 12000) begin
            do_tick();
            n++;
            if (!regated && m_env[1] == 8'h40) begin
                bus.gate[1] = 1'b1;
                regated = 1'b1;
                rg = n;
            end
            if (regated && !checked && n == rg + 50) begin
                checked = 1'b1;
                total++; if (bus.env_flat[15:8] !== 8'h45) begin bad++;
                    $display("FAIL regate_attack: env1=%h want 45", bus.env_flat[15:8]); end
            end
        end
        if (!checked) begin
            total++; bad++;
            $display("FAIL regate_reached: env1 never regated at 40, got %h", bus.env_flat[15:8]);
        end
        repeat (30) do_tick();
        total++; if (bus.env_flat[7:0] !== 8'h00) begin bad++;
            $display("FAIL release_floor: env0=%h want 00", bus.env_flat[7:0]); end
        total++; if (bus.env_flat[23:16] !== 8'h88) begin bad++;
            $display("FAIL sustain_88: env2=%h want 88", bus.env_flat[23:16]); end
    endtask

    task automatic test_gate_isolation();
        apply_reset();
        bus.ad_flat = 24'h000000;
        bus.sr_flat = 24'h0000f0;
        bus.gate    = 3'b001;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) bus.gate[2] = ~bus.gate[2];
            do_tick();
        end
        total++; if (bus.env_flat[7:0] !== 8'h04) begin bad++;
            $display("FAIL isolation_env0: env0=%h want 04", bus.env_flat[7:0]); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        model_tick(); model_tick();
        bus.tick = 1'b1;
        repeat (2) @(negedge clk);
        bus.tick = 1'b0;
        pulses = 0;
        repeat (20) begin @(negedge clk); if (bus.env_valid) pulses++; end
        total++; if (pulses !== 2) begin bad++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        total++; if (bus.overrun !== 1'b0) begin bad++;
            $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
        model_tick(); model_tick();
        bus.tick = 1'b1;
        repeat (3) @(negedge clk);
        bus.tick = 1'b0;
        pulses = 0;
        repeat (20) begin @(negedge clk); if (bus.env_valid) pulses++; end
        total++; if (pulses !== 2) begin bad++;
            $display("FAIL drop_pulses: got %0d want 2", pulses); end
        total++; if (bus.overrun !== 1'b1) begin bad++;
            $display("FAIL drop_overrun: got %b want 1", bus.overrun); end
        do_tick();
        total++; if (bus.overrun !== 1'b1) begin bad++;
            $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
        apply_reset();
        repeat (10) begin @(negedge clk); if (bus.env_valid) pulses++; end
        total++; if (pulses !== 0) begin bad++;
            $display("FAIL abort_pulses: got %0d want 0", pulses); end
        total++; if (bus.overrun !== 1'b0) begin bad++;
            $display("FAIL abort_overrun: got %b want 0", bus.overrun); end
        total++; if (bus.env_flat !== 24'h0) begin bad++;
            $display("FAIL abort_env: got %h want 000000", bus.env_flat); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_attack();
        test_release_regate();
        test_gate_isolation();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
